// File: rtl/lifo_pkg.sv
// Shared constants for the operand/opcode LIFO: default geometry and the
// opcode tag encodings the ALU datapath writes into each entry.
package lifo_pkg;

   localparam int DEF_DATA_W = 6;
   localparam int DEF_TAG_W  = 3;
   localparam int DEF_DEPTH  = 8;

   typedef enum logic [2:0] {
      OP_NOP = 3'd0,
      OP_ADD = 3'd1,
      OP_SUB = 3'd2,
      OP_AND = 3'd3,
      OP_OR  = 3'd4,
      OP_XOR = 3'd5,
      OP_SHL = 3'd6,
      OP_SHR = 3'd7
   } opcode_e;

   function automatic int addr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/lifo_ptr_ctrl.sv
// Occupancy and handshake control for the LIFO: count/full/empty, push_ready,
// accept/replace decode, storage addresses and registered error pulses.
module lifo_ptr_ctrl
   import lifo_pkg::*;
#(
   parameter int DEPTH  = DEF_DEPTH,
   parameter int CNT_W  = $clog2(DEPTH + 1),
   parameter int ADDR_W = addr_width(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push_valid,
   input  logic              pop_req,
   output logic              push_ready,
   output logic              push_acc,
   output logic              pop_acc,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
   output logic              underflow
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [CNT_W-1:0] top_idx;

   assign full       = (count == CNT_MAX);
   assign empty      = (count == '0);
   assign pop_acc    = pop_req & ~empty;
   assign push_ready = ~full | pop_acc;
   assign push_acc   = push_valid & push_ready;

   // On replace the new word overwrites the slot being popped, so a word
   // pushed this cycle can never be the one returned this cycle.
   assign top_idx = count - CNT_ONE;
   assign rd_addr = ADDR_W'(top_idx);
   assign wr_addr = pop_acc ? ADDR_W'(top_idx) : ADDR_W'(count);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count     <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values regardless of statement order.
         overflow  <= push_valid & ~push_ready;
         underflow <= pop_req & empty;
         if (push_acc && !pop_acc) begin
            count <= count + CNT_ONE;
         end else if (pop_acc && !push_acc) begin
            count <= count - CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/lifo_stack_param.sv
// Parametrised data+tag LIFO with ready/valid push and registered pop output.
// Define LIFO_TOP_PEEK_EN to add the combinational top_data/top_tag peek ports.
module lifo_stack_param
   import lifo_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int TAG_W  = DEF_TAG_W,
   parameter int DEPTH  = DEF_DEPTH,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push_valid,
   input  logic [DATA_W-1:0] push_data,
   input  logic [TAG_W-1:0]  push_tag,
   output logic              push_ready,
   input  logic              pop_req,
   output logic              rd_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [CNT_W-1:0]  count,
   output logic              full,
   output logic              empty,
   output logic              overflow,
`ifdef LIFO_TOP_PEEK_EN
   output logic              underflow,
   output logic [DATA_W-1:0] top_data,
   output logic [TAG_W-1:0]  top_tag
`else
   output logic              underflow
`endif
);

   localparam int ADDR_W = addr_width(DEPTH);

   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [TAG_W-1:0]  tag_mem  [DEPTH];
   logic              push_acc;
   logic              pop_acc;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;

   lifo_ptr_ctrl #(
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W),
      .ADDR_W (ADDR_W)
   ) u_ptr_ctrl (
      .clk        (clk),
      .reset_n    (reset_n),
      .push_valid (push_valid),
      .pop_req    (pop_req),
      .push_ready (push_ready),
      .push_acc   (push_acc),
      .pop_acc    (pop_acc),
      .wr_addr    (wr_addr),
      .rd_addr    (rd_addr),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .overflow   (overflow),
      .underflow  (underflow)
   );

   // NOTE: storage has no reset; count=0 makes stale contents unreachable,
   // and leaving it unreset lets it map onto plain RAM/flops without reset.
   always_ff @(posedge clk) begin
      if (push_acc) begin
         data_mem[wr_addr] <= push_data;
         tag_mem[wr_addr]  <= push_tag;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_tag   <= '0;
      end else begin
         rd_valid <= pop_acc;
         if (pop_acc) begin
            rd_data <= data_mem[rd_addr];
            rd_tag  <= tag_mem[rd_addr];
         end
      end
   end

`ifdef LIFO_TOP_PEEK_EN
   always_comb begin
      // NOTE: defaults first so every path assigns and no latch is inferred.
      top_data = '0;
      top_tag  = '0;
      if (!empty) begin
         top_data = data_mem[rd_addr];
         top_tag  = tag_mem[rd_addr];
      end
   end
`endif

endmodule

// File: tb/tb_lifo_stack_param.sv
// Directed self-checking bench for lifo_stack_param (DATA_W=6, TAG_W=3, DEPTH=8).
module tb_lifo_stack_param;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       push_valid;
   logic [5:0] push_data;
   logic [2:0] push_tag;
   logic       push_ready;
   logic       pop_req;
   logic       rd_valid;
   logic [5:0] rd_data;
   logic [2:0] rd_tag;
   logic [3:0] count;
   logic       full;
   logic       empty;
   logic       overflow;
   logic       underflow;
`ifdef LIFO_TOP_PEEK_EN
   logic [5:0] top_data;
   logic [2:0] top_tag;
`endif

   int errors = 0;
   int checks = 0;

   lifo_stack_param #(.DATA_W(6), .TAG_W(3), .DEPTH(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .push_valid (push_valid),
      .push_data  (push_data),
      .push_tag   (push_tag),
      .push_ready (push_ready),
      .pop_req    (pop_req),
      .rd_valid   (rd_valid),
      .rd_data    (rd_data),
      .rd_tag     (rd_tag),
      .count      (count),
      .full       (full),
      .empty      (empty),
      .overflow   (overflow),
`ifdef LIFO_TOP_PEEK_EN
      .underflow  (underflow),
      .top_data   (top_data),
      .top_tag    (top_tag)
`else
      .underflow  (underflow)
`endif
   );

   always #5 clk = ~clk;

   // Inputs change 1 ns after a rising edge; outputs are sampled there too.
   task automatic drive(input logic pv, input logic [5:0] d, input logic [2:0] t, input logic pr);
      push_valid = pv;
      push_data  = d;
      push_tag   = t;
      pop_req    = pr;
   endtask

   task automatic step(input logic pv, input logic [5:0] d, input logic [2:0] t, input logic pr);
      drive(pv, d, t, pr);
      @(posedge clk);
      #1;
      drive(1'b0, 6'h00, 3'd0, 1'b0);
   endtask

   task automatic test_reset;
      drive(1'b0, 6'h00, 3'd0, 1'b0);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({count, empty, full, rd_valid, rd_data, rd_tag, overflow, underflow} !==
          {4'd0, 1'b1, 1'b0, 1'b0, 6'h00, 3'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: cnt=%0d e=%b f=%b v=%b d=%h t=%0d ov=%b un=%b",
                  count, empty, full, rd_valid, rd_data, rd_tag, overflow, underflow);
      end
      checks++;
      if (push_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_push_ready: got %b want 1", push_ready);
      end
   endtask

   task automatic test_push_pop;
      step(1'b1, 6'h15, 3'd2, 1'b0);
      step(1'b1, 6'h2A, 3'd5, 1'b0);
      checks++;
      if ({count, empty} !== {4'd2, 1'b0}) begin
         errors++;
         $display("FAIL pp_count2: cnt=%0d e=%b want 2/0", count, empty);
      end
`ifdef LIFO_TOP_PEEK_EN
      checks++;
      if ({top_data, top_tag} !== {6'h2A, 3'd5}) begin
         errors++;
         $display("FAIL pp_peek: got %h/%0d want 2a/5", top_data, top_tag);
      end
`endif
      step(1'b0, 6'h00, 3'd0, 1'b1);
      checks++;
      if ({rd_valid, rd_data, rd_tag, count} !== {1'b1, 6'h2A, 3'd5, 4'd1}) begin
         errors++;
         $display("FAIL pp_pop1: v=%b d=%h t=%0d cnt=%0d want 1/2a/5/1", rd_valid, rd_data, rd_tag, count);
      end
      step(1'b0, 6'h00, 3'd0, 1'b1);
      checks++;
      if ({rd_valid, rd_data, rd_tag, count, empty} !== {1'b1, 6'h15, 3'd2, 4'd0, 1'b1}) begin
         errors++;
         $display("FAIL pp_pop2: v=%b d=%h t=%0d cnt=%0d e=%b want 1/15/2/0/1",
                  rd_valid, rd_data, rd_tag, count, empty);
      end
      step(1'b0, 6'h00, 3'd0, 1'b0);
      checks++;
      if ({rd_valid, rd_data, rd_tag, underflow} !== {1'b0, 6'h15, 3'd2, 1'b0}) begin
         errors++;
         $display("FAIL pp_idle_hold: v=%b d=%h t=%0d un=%b want 0/15/2/0", rd_valid, rd_data, rd_tag, underflow);
      end
   endtask

   task automatic test_full_overflow;
      for (int i = 1; i <= 8; i++) step(1'b1, 6'(i), 3'(i), 1'b0);
      drive(1'b1, 6'h09, 3'd1, 1'b0);
      #1;
      checks++;
      if ({full, push_ready, count} !== {1'b1, 1'b0, 4'd8}) begin
         errors++;
         $display("FAIL full_ready: f=%b rdy=%b cnt=%0d want 1/0/8", full, push_ready, count);
      end
      @(posedge clk);
      #1;
      drive(1'b0, 6'h00, 3'd0, 1'b0);
      checks++;
      if ({overflow, count, full} !== {1'b1, 4'd8, 1'b1}) begin
         errors++;
         $display("FAIL full_overflow: ov=%b cnt=%0d f=%b want 1/8/1", overflow, count, full);
      end
      step(1'b0, 6'h00, 3'd0, 1'b1);
      checks++;
      if ({overflow, rd_valid, rd_data, rd_tag, count} !== {1'b0, 1'b1, 6'h08, 3'd0, 4'd7}) begin
         errors++;
         $display("FAIL full_pop_top: ov=%b v=%b d=%h t=%0d cnt=%0d want 0/1/08/0/7",
                  overflow, rd_valid, rd_data, rd_tag, count);
      end
      for (int i = 0; i < 7; i++) step(1'b0, 6'h00, 3'd0, 1'b1);
      checks++;
      if ({count, empty, rd_data} !== {4'd0, 1'b1, 6'h01}) begin
         errors++;
         $display("FAIL full_drain: cnt=%0d e=%b d=%h want 0/1/01", count, empty, rd_data);
      end
   endtask

   task automatic test_replace;
      for (int i = 1; i <= 3; i++) step(1'b1, 6'(i), 3'd1, 1'b0);
      step(1'b1, 6'h3F, 3'd6, 1'b1);
      checks++;
      if ({rd_valid, rd_data, rd_tag, count} !== {1'b1, 6'h03, 3'd1, 4'd3}) begin
         errors++;
         $display("FAIL replace_pop: v=%b d=%h t=%0d cnt=%0d want 1/03/1/3", rd_valid, rd_data, rd_tag, count);
      end
      step(1'b0, 6'h00, 3'd0, 1'b1);
      checks++;
      if ({rd_data, rd_tag, count} !== {6'h3F, 3'd6, 4'd2}) begin
         errors++;
         $display("FAIL replace_next: d=%h t=%0d cnt=%0d want 3f/6/2", rd_data, rd_tag, count);
      end
      step(1'b0, 6'h00, 3'd0, 1'b1);
      step(1'b0, 6'h00, 3'd0, 1'b1);
      checks++;
      if ({rd_data, count} !== {6'h01, 4'd0}) begin
         errors++;
         $display("FAIL replace_drain: d=%h cnt=%0d want 01/0", rd_data, count);
      end
   endtask

   task automatic test_underflow;
      step(1'b0, 6'h00, 3'd0, 1'b1);
      checks++;
      if ({underflow, rd_valid, rd_data, count} !== {1'b1, 1'b0, 6'h01, 4'd0}) begin
         errors++;
         $display("FAIL underflow_pulse: un=%b v=%b d=%h cnt=%0d want 1/0/01/0", underflow, rd_valid, rd_data, count);
      end
      step(1'b1, 6'h11, 3'd4, 1'b1);
      checks++;
      if ({underflow, rd_valid, rd_data, count, empty} !== {1'b1, 1'b0, 6'h01, 4'd1, 1'b0}) begin
         errors++;
         $display("FAIL underflow_push: un=%b v=%b d=%h cnt=%0d e=%b want 1/0/01/1/0",
                  underflow, rd_valid, rd_data, count, empty);
      end
      step(1'b0, 6'h00, 3'd0, 1'b1);
      checks++;
      if ({underflow, rd_valid, rd_data, rd_tag, count} !== {1'b0, 1'b1, 6'h11, 3'd4, 4'd0}) begin
         errors++;
         $display("FAIL underflow_recover: un=%b v=%b d=%h t=%0d cnt=%0d want 0/1/11/4/0",
                  underflow, rd_valid, rd_data, rd_tag, count);
      end
   endtask

   task automatic test_full_replace;
      for (int i = 0; i < 8; i++) step(1'b1, 6'(8'h30 + i), 3'd3, 1'b0);
      drive(1'b1, 6'h20, 3'd7, 1'b1);
      #1;
      checks++;
      if ({full, push_ready} !== {1'b1, 1'b1}) begin
         errors++;
         $display("FAIL full_replace_ready: f=%b rdy=%b want 1/1", full, push_ready);
      end
      @(posedge clk);
      #1;
      drive(1'b0, 6'h00, 3'd0, 1'b0);
      checks++;
      if ({overflow, rd_valid, rd_data, count} !== {1'b0, 1'b1, 6'h37, 4'd8}) begin
         errors++;
         $display("FAIL full_replace: ov=%b v=%b d=%h cnt=%0d want 0/1/37/8", overflow, rd_valid, rd_data, count);
      end
      step(1'b0, 6'h00, 3'd0, 1'b1);
      checks++;
      if ({rd_data, rd_tag, count} !== {6'h20, 3'd7, 4'd7}) begin
         errors++;
         $display("FAIL full_replace_next: d=%h t=%0d cnt=%0d want 20/7/7", rd_data, rd_tag, count);
      end
   endtask

   task automatic test_async_reset;
      reset_n = 1'b0;
      @(posedge clk);
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) step(1'b1, 6'(8'h0A + i), 3'd2, 1'b0);
      step(1'b0, 6'h00, 3'd0, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({count, empty, rd_valid, rd_data, rd_tag} !== {4'd0, 1'b1, 1'b0, 6'h00, 3'd0}) begin
         errors++;
         $display("FAIL async_reset: cnt=%0d e=%b v=%b d=%h t=%0d want 0/1/0/00/0",
                  count, empty, rd_valid, rd_data, rd_tag);
      end
`ifdef LIFO_TOP_PEEK_EN
      checks++;
      if ({top_data, top_tag} !== {6'h00, 3'd0}) begin
         errors++;
         $display("FAIL async_reset_peek: got %h/%0d want 00/0", top_data, top_tag);
      end
`endif
      #3 reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b1;
      drive(1'b0, 6'h00, 3'd0, 1'b0);
      #1;
      test_reset();
      test_push_pop();
      test_full_overflow();
      test_replace();
      test_underflow();
      test_full_replace();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
